// File: rtl/execute_stage_if.sv
// Y86-64 execute stage bundle: D->E operands, stage status
// inputs, forwarding outputs and the E->M register contents.
interface execute_stage_if #(
  parameter int DATA_W = 64
);
  logic              M_bubble;
  logic [3:0]        E_stat;
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [DATA_W-1:0] E_valC;
  logic [DATA_W-1:0] E_valA;
  logic [DATA_W-1:0] E_valB;
  logic [3:0]        E_dstE;
  logic [3:0]        E_dstM;
  logic [3:0]        m_stat;
  logic [3:0]        W_stat;
  logic              e_Cnd;
  logic [DATA_W-1:0] e_valE;
  logic [3:0]        e_dstE;
  logic [2:0]        cc_out;
  logic [3:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;

  modport master (
    output M_bubble, E_stat, E_icode, E_ifun,
    output E_valC, E_valA, E_valB, E_dstE, E_dstM,
    output m_stat, W_stat,
    input  e_Cnd, e_valE, e_dstE, cc_out,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA,
    input  M_dstE, M_dstM
  );

  modport slave (
    input  M_bubble, E_stat, E_icode, E_ifun,
    input  E_valC, E_valA, E_valB, E_dstE, E_dstM,
    input  m_stat, W_stat,
    output e_Cnd, e_valE, e_dstE, cc_out,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA,
    output M_dstE, M_dstM
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov
// condition and E->M register. Macro EXEC_IADDQ_EN adds iaddq.
module execute_stage #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  execute_stage_if.slave ex
);

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] I_NOP = 4'h1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  localparam logic [DATA_W-1:0] K_P8 = DATA_W'(8);
  localparam logic [DATA_W-1:0] K_M8 = ~K_P8 + 1'b1;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] res;
  logic [1:0]        alu_fn;
  logic              zf_n;
  logic              sf_n;
  logic              of_n;
  logic              cc_op;
  logic              set_cc;
  logic              cnd;
  logic              zf;
  logic              sf;
  logic              of;
  logic [2:0]        cc_q;

  logic [3:0]        m_stat_q;
  logic [3:0]        m_icode_q;
  logic              m_cnd_q;
  logic [DATA_W-1:0] m_vale_q;
  logic [DATA_W-1:0] m_vala_q;
  logic [3:0]        m_dste_q;
  logic [3:0]        m_dstm_q;

  // Operand A select by instruction class
  always_comb begin
    alu_a = '0;
    case (ex.E_icode)
      4'h2, 4'h6:       alu_a = ex.E_valA;
      4'h3, 4'h4, 4'h5: alu_a = ex.E_valC;
      4'h8, 4'hA:       alu_a = K_M8;
      4'h9, 4'hB:       alu_a = K_P8;
`ifdef EXEC_IADDQ_EN
      4'hC:             alu_a = ex.E_valC;
`endif
      default:          alu_a = '0;
    endcase
  end

  // Operand B select by instruction class
  always_comb begin
    alu_b = '0;
    case (ex.E_icode)
      4'h4, 4'h5, 4'h6,
      4'h8, 4'h9, 4'hA,
      4'hB:    alu_b = ex.E_valB;
`ifdef EXEC_IADDQ_EN
      4'hC:    alu_b = ex.E_valB;
`endif
      default: alu_b = '0;
    endcase
  end

  // Only OPq picks its function; unknown ifun falls back to add
  always_comb begin
    alu_fn = OP_ADD;
    if (ex.E_icode == 4'h6 && ex.E_ifun <= 4'h3)
      alu_fn = ex.E_ifun[1:0];
  end

  // ALU result and the flags it would produce
  always_comb begin
    res  = '0;
    of_n = 1'b0;
    case (alu_fn)
      OP_ADD: begin
        res  = alu_b + alu_a;
        of_n = (alu_a[DATA_W-1] == alu_b[DATA_W-1])
             && (res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        res  = alu_b - alu_a;
        of_n = (alu_a[DATA_W-1] != alu_b[DATA_W-1])
             && (res[DATA_W-1] != alu_b[DATA_W-1]);
      end
      OP_AND:  res = alu_b & alu_a;
      OP_XOR:  res = alu_b ^ alu_a;
      default: res = '0;
    endcase
    zf_n = (res == '0);
    sf_n = res[DATA_W-1];
  end

  // CC writers are squashed if a later stage has faulted
  always_comb begin
    cc_op = (ex.E_icode == 4'h6);
`ifdef EXEC_IADDQ_EN
    cc_op = cc_op || (ex.E_icode == 4'hC);
`endif
    set_cc = cc_op
           && (ex.m_stat == S_AOK)
           && (ex.W_stat == S_AOK);
  end

  // Condition uses CC as it stood before this edge
  always_comb begin
    zf  = cc_q[2];
    sf  = cc_q[1];
    of  = cc_q[0];
    cnd = 1'b0;
    case (ex.E_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of) | zf;
      4'h2:    cnd = sf ^ of;
      4'h3:    cnd = zf;
      4'h4:    cnd = ~zf;
      4'h5:    cnd = ~(sf ^ of);
      4'h6:    cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  assign ex.e_Cnd  = cnd;
  assign ex.e_valE = res;
  assign ex.e_dstE = (ex.E_icode == 4'h2 && !cnd)
                   ? RNONE : ex.E_dstE;

  // Condition code register {ZF,SF,OF}
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cc_q <= 3'b100;
    else if (set_cc)
      cc_q <= {zf_n, sf_n, of_n};
  end

  // E->M pipeline register with bubble injection
  always_ff @(posedge clk or posedge rst) begin
    if (rst || ex.M_bubble) begin
      m_stat_q  <= S_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
    end else begin
      m_stat_q  <= ex.E_stat;
      m_icode_q <= ex.E_icode;
      m_cnd_q   <= cnd;
      m_vale_q  <= res;
      m_vala_q  <= ex.E_valA;
      m_dste_q  <= ex.e_dstE;
      m_dstm_q  <= ex.E_dstM;
    end
  end

  assign ex.cc_out  = cc_q;
  assign ex.M_stat  = m_stat_q;
  assign ex.M_icode = m_icode_q;
  assign ex.M_Cnd   = m_cnd_q;
  assign ex.M_valE  = m_vale_q;
  assign ex.M_valA  = m_vala_q;
  assign ex.M_dstE  = m_dste_q;
  assign ex.M_dstM  = m_dstm_q;

endmodule
